// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding and phase-counter sizing shared by reset_sequencer
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_PRE,
        S_ASSERT,
        S_RELEASE,
        S_RUN,
        S_HALT
    } state_e;

    // Width needed to hold the largest phase count (at least one bit)
    function automatic int phase_w(input int pre, input int pulse, input int span);
        int m;
        m = pre;
        if (pulse > m) m = pulse;
        if (span > m) m = span;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// reset_sequencer: power-on / software reset sequencing with staggered channel release and run limit
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int PRE_CYCLES     = 18,
    parameter int PULSE_CYCLES   = 2,
    parameter int NUM_CHANNELS   = 1,
    parameter int STAGGER_CYCLES = 0,
    parameter int RUN_CYCLES     = 0,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sw_req,
    output logic [NUM_CHANNELS-1:0] chan_rst,
    output logic                    run,
    output logic                    halted,
    output logic [CNT_W-1:0]        cycle_count
);

    // Edges from the first channel release to the last one
    localparam int LAST = (NUM_CHANNELS - 1) * STAGGER_CYCLES;
    localparam int PW   = phase_w(PRE_CYCLES, PULSE_CYCLES, LAST);

    if (RUN_CYCLES < 0 || (CNT_W < 31 && RUN_CYCLES > (1 << CNT_W) - 1)) begin : g_bad_run_cycles
        $error("reset_sequencer: RUN_CYCLES does not fit in CNT_W bits");
    end

    state_e                  state_q, state_d;
    logic [PW-1:0]           cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0] chan_q, chan_d, hit;
    logic                    run_q, run_d;
    logic                    halted_q, halted_d;
    logic [CNT_W-1:0]        cc_q, cc_d;

    // Channel g drops when the edge about to happen is g*STAGGER_CYCLES after channel 0 dropped
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_hit
        assign hit[g] = (int'(cnt_q) + 1 == g * STAGGER_CYCLES);
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        chan_d   = chan_q;
        run_d    = run_q;
        halted_d = halted_q;
        cc_d     = cc_q;
        case (state_q)
            S_PRE, S_ASSERT: begin
                if (int'(cnt_q) == ((state_q == S_PRE) ? PRE_CYCLES : PULSE_CYCLES) - 1) begin
                    cnt_d     = '0;
                    chan_d[0] = 1'b0;
                    state_d   = (LAST == 0) ? S_RUN : S_RELEASE;
                    if (LAST == 0) begin
                        chan_d = '0;
                        run_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                cnt_d  = cnt_q + 1'b1;
                chan_d = chan_q & ~hit;
                if (int'(cnt_q) + 1 == LAST) begin
                    state_d = S_RUN;
                    run_d   = 1'b1;
                end
            end
            S_RUN, S_HALT: begin
                if (sw_req) begin
                    state_d  = S_ASSERT;
                    cnt_d    = '0;
                    chan_d   = '1;
                    run_d    = 1'b0;
                    halted_d = 1'b0;
                    cc_d     = '0;
                end else if (state_q == S_RUN) begin
                    if (RUN_CYCLES != 0 && cc_q == CNT_W'(RUN_CYCLES - 1)) begin
                        state_d  = S_HALT;
                        chan_d   = '1;
                        run_d    = 1'b0;
                        halted_d = 1'b1;
                        cc_d     = CNT_W'(RUN_CYCLES);
                    end else if (cc_q != '1) begin
                        cc_d = cc_q + 1'b1;
                    end
                end
            end
            default: state_d = S_PRE;
        endcase
    end

    // State and output registers; rst takes effect without a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_PRE;
            cnt_q    <= '0;
            chan_q   <= '1;
            run_q    <= 1'b0;
            halted_q <= 1'b0;
            cc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chan_q   <= chan_d;
            run_q    <= run_d;
            halted_q <= halted_d;
            cc_q     <= cc_d;
        end
    end

    assign chan_rst    = chan_q;
    assign run         = run_q;
    assign halted      = halted_q;
    assign cycle_count = cc_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter PRE_CYCLES, default 18: rising edges after rst release before the first channel release; legal range >= 1.
REQ-002 Parameter PULSE_CYCLES, default 2: reset pulse length in edges for a software-requested reset; legal range >= 1.
REQ-003 Parameter NUM_CHANNELS, default 1: number of independent reset outputs; legal range >= 1.
REQ-004 Parameter STAGGER_CYCLES, default 0: edges between successive channel releases.
REQ-005 Parameter RUN_CYCLES, default 0: run limit in edges; 0 means unlimited.
REQ-006 Parameter CNT_W, default 16: cycle_count width.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 sw_req  input  1  synchronous request for a new reset pulse, sampled each edge.
REQ-010 chan_rst  output  NUM_CHANNELS  per-channel reset to downstream logic (e.g. cpu instances), active-high, registered.
REQ-011 run  output  1  high while all channels are released and the run limit is not reached.
REQ-012 halted  output  1  high after the run limit is reached.
REQ-013 cycle_count  output  CNT_W  edges spent in RUN since the last release.

Function
REQ-014 States: PRE, ASSERT, RELEASE, RUN, HALT; one internal phase counter sized to the largest of PRE_CYCLES, PULSE_CYCLES and (NUM_CHANNELS-1)*STAGGER_CYCLES.
REQ-015 PRE: chan_rst all ones; count edges; on the PRE_CYCLES-th edge after rst release, enter RELEASE and drop chan_rst[0] on that same edge.
REQ-016 RELEASE: chan_rst[i] drops on the edge i*STAGGER_CYCLES after chan_rst[0] drops; released channels stay low.
REQ-017 On the edge the last channel drops: enter RUN, run=1, cycle_count=0. With STAGGER_CYCLES=0 or NUM_CHANNELS=1, PRE goes straight to RUN.
REQ-018 RUN: cycle_count increments by 1 each edge and saturates at 2^CNT_W-1.
REQ-019 With RUN_CYCLES!=0, the edge on which cycle_count would become RUN_CYCLES instead:
- enters HALT
- sets run=0, halted=1, chan_rst all ones
- sets cycle_count=RUN_CYCLES (so run is high for exactly RUN_CYCLES cycles).
REQ-020 HALT: holds all outputs until sw_req or rst.
REQ-021 sw_req=1 in RUN or HALT, on that edge:
- enters ASSERT
- sets chan_rst all ones, run=0, halted=0, cycle_count=0.
REQ-022 ASSERT: after PULSE_CYCLES edges, enter RELEASE per REQ-016/REQ-017; the first channel drops on the PULSE_CYCLES-th edge.
REQ-023 sw_req is ignored in PRE, ASSERT and RELEASE.
REQ-024 sw_req on the same edge as the run-limit edge: sw_req wins, ASSERT entered, halted stays 0.
REQ-025 RUN_CYCLES must fit in CNT_W bits; this is a checked elaboration error otherwise.

Reset
REQ-026 rst=1 immediately, without waiting for a clock edge, forces: state=PRE, phase counter=0, chan_rst all ones, run=0, halted=0, cycle_count=0; this applies from any state, including mid-RELEASE or mid-ASSERT.
REQ-027 After rst deasserts, the sequence restarts from REQ-015; no prior state is retained.

Structure
REQ-028 Package reset_seq_pkg holds the state enum and the phase-counter width function; the module imports it.
REQ-029 Single module, no sub-module; phase counter and per-channel release compare are inline.

Verification
REQ-030 Defaults, rst pulse, then sw_req=0 -> chan_rst[0] falls on the 18th edge after rst release; run=1 on the same edge; cycle_count=0, then increments by 1 per edge.
REQ-031 NUM_CHANNELS=3, STAGGER_CYCLES=2, PRE_CYCLES=4 -> chan_rst bits fall on edges 4, 6 and 8; run rises on edge 8.
REQ-032 RUN_CYCLES=5 -> run high for exactly 5 cycles, then halted=1, chan_rst all ones, cycle_count=5, held for 20 further edges.
REQ-033 sw_req for one cycle in RUN, PULSE_CYCLES=2 -> chan_rst all ones, cycle_count=0, run=0 immediately; release on the 2nd edge after the request.
REQ-034 rst asserted between channel-1 and channel-2 release (config of REQ-031) -> chan_rst all ones with no clock edge; sequence restarts, release on edge 4 after rst drop.
REQ-035 RUN_CYCLES=5 with sw_req on the limit edge -> ASSERT entered, halted never rises; sw_req held high during ASSERT causes no extra pulse.
